// File: rtl/pwm_nch_if.sv
// Duty-write port of pwm_nch: valid/ready write of one channel's duty value,
// with a one-cycle error pulse for an out-of-range channel index.
interface pwm_nch_if #(
  parameter int N  = 8,
  parameter int CH = 4
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic           wr_en;
  logic [CHW-1:0] wr_ch;
  logic [N-1:0]   wr_duty;
  logic           wr_ready;
  logic           wr_err;

  modport master (output wr_en, wr_ch, wr_duty, input  wr_ready, wr_err);
  modport slave  (input  wr_en, wr_ch, wr_duty, output wr_ready, wr_err);
endinterface

// File: rtl/pwm_nch.sv
// Multi-channel edge-aligned PWM with shared prescaler/period counter and double-buffered
// duty/period. Define PWM_NCH_CENTER_EN to add the `center` input (up/down counting).
module pwm_nch #(
  parameter int N     = 8,
  parameter int CH    = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic [N-1:0]     period,
`ifdef PWM_NCH_CENTER_EN
  input  logic             center,
`endif
  pwm_nch_if.slave         wr,
  output logic             cycle_start,
  output logic [CH-1:0]    pwm_out
);
  localparam int            CHW    = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CHW:0]  CH_LIM = (CHW + 1)'(CH);

  logic [PRE_W-1:0] r_pre_cnt;
  logic [N-1:0]     r_cnt;
  logic [N-1:0]     r_period_q;
  logic [N-1:0]     r_duty_sh  [CH];
  logic [N-1:0]     r_duty_act [CH];

  logic w_tick;
  logic w_boundary;
  logic w_accept;
  logic w_ch_ok;

  assign w_tick = en & (r_pre_cnt == prescale);

`ifdef PWM_NCH_CENTER_EN
  logic r_down;
  logic r_center;
  logic w_turn;

  // Counting down, or at the top: the next tick moves the counter downwards.
  assign w_turn     = r_down | (r_cnt == r_period_q);
  assign w_boundary = w_tick & (r_center
                      ? ((r_period_q == '0) | (w_turn & (r_cnt == N'(1))))
                      : (r_cnt == r_period_q));
`else
  assign w_boundary = w_tick & (r_cnt == r_period_q);
`endif

  assign wr.wr_ready = ~reset & ~w_boundary;
  assign w_accept    = wr.wr_en & wr.wr_ready;
  assign w_ch_ok     = {1'b0, wr.wr_ch} < CH_LIM;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt   <= '0;
      r_cnt       <= '0;
      r_period_q  <= '0;
      cycle_start <= 1'b0;
      wr.wr_err   <= 1'b0;
      pwm_out     <= '0;
      // NOTE: the duty arrays are tiny flop banks that must come up as 0% duty, so unlike
      // a RAM they are cleared element by element on reset.
      for (int i = 0; i < CH; i++) begin
        r_duty_sh[i]  <= '0;
        r_duty_act[i] <= '0;
      end
`ifdef PWM_NCH_CENTER_EN
      r_down   <= 1'b0;
      r_center <= 1'b0;
`endif
    end else begin
      cycle_start <= w_boundary;
      wr.wr_err   <= w_accept & ~w_ch_ok;

      for (int i = 0; i < CH; i++) begin
        if (w_accept && w_ch_ok && (wr.wr_ch == CHW'(i)))
          r_duty_sh[i] <= wr.wr_duty;
      end

      if (!en) begin
        // Idle: keep the shadow values live so the first enabled period uses them.
        r_pre_cnt  <= '0;
        r_cnt      <= '0;
        r_period_q <= period;
        for (int i = 0; i < CH; i++) r_duty_act[i] <= r_duty_sh[i];
`ifdef PWM_NCH_CENTER_EN
        r_down   <= 1'b0;
        r_center <= center;
`endif
      end else begin
        r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;

        if (w_tick) begin
`ifdef PWM_NCH_CENTER_EN
          if (r_center) begin
            if (r_period_q == '0) begin
              r_cnt  <= '0;
              r_down <= 1'b0;
            end else if (w_turn) begin
              r_cnt  <= r_cnt - 1'b1;
              r_down <= (r_cnt > N'(1));
            end else begin
              r_cnt  <= r_cnt + 1'b1;
              r_down <= 1'b0;
            end
          end else begin
            r_cnt  <= (r_cnt == r_period_q) ? '0 : r_cnt + 1'b1;
            r_down <= 1'b0;
          end
`else
          r_cnt <= (r_cnt == r_period_q) ? '0 : r_cnt + 1'b1;
`endif
        end

        if (w_boundary) begin
          r_period_q <= period;
          for (int i = 0; i < CH; i++) r_duty_act[i] <= r_duty_sh[i];
`ifdef PWM_NCH_CENTER_EN
          r_center <= center;
`endif
        end
      end

      for (int i = 0; i < CH; i++)
        pwm_out[i] <= en & (r_cnt < r_duty_act[i]);
    end
  end
endmodule
